// File: rtl/fpu_req_shell_if.sv
// Request, core-side and response signal bundle for fpu_req_shell.
// The shell uses the slave view; whatever drives requests and hosts the core uses master.
interface fpu_req_shell_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [1:0]       in_rmode;
  logic [WIDTH-1:0] in_opa;
  logic [WIDTH-1:0] in_opb;
  logic [TAG_W-1:0] in_tag;

  logic [2:0]       core_op;
  logic [1:0]       core_rmode;
  logic [WIDTH-1:0] core_opa;
  logic [WIDTH-1:0] core_opb;
  logic [WIDTH-1:0] core_out;
  logic [7:0]       core_flags;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [7:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic [7:0]       sticky_flags;
  logic             clr_sticky;

  modport slave (
    input  in_valid, in_op, in_rmode, in_opa, in_opb, in_tag,
    output in_ready,
    output core_op, core_rmode, core_opa, core_opb,
    input  core_out, core_flags,
    output out_valid, out_result, out_flags, out_tag, sticky_flags,
    input  out_ready, clr_sticky
  );

  modport master (
    output in_valid, in_op, in_rmode, in_opa, in_opb, in_tag,
    input  in_ready,
    input  core_op, core_rmode, core_opa, core_opb,
    output core_out, core_flags,
    input  out_valid, out_result, out_flags, out_tag, sticky_flags,
    output out_ready, clr_sticky
  );
endinterface

// File: rtl/fpu_req_shell.sv
// Request/response shell around a fixed-latency pipelined FPU core: issue register,
// in-flight tag pipe, result FIFO with credit-style backpressure, illegal-op bypass, sticky flags.
module fpu_req_shell #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  fpu_req_shell_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PCW = CW + 1;
  localparam logic [63:0] QNAN_FULL = (WIDTH == 64) ? 64'h7FF8_0000_0000_0000 :
                                      (WIDTH == 32) ? 64'h0000_0000_7FC0_0000 :
                                                      64'h0000_0000_0000_7E00;
  localparam logic [WIDTH-1:0] QNAN       = QNAN_FULL[WIDTH-1:0];
  localparam logic [7:0]       QNAN_FLAGS = 8'h40;
  localparam logic [2:0]       OP_ILLEGAL = 3'd7;

  logic             accept_s;
  logic             wr_s;
  logic             pop_s;
  logic             in_ready_s;
  logic [PCW-1:0]   pending_s;
  logic [WIDTH-1:0] wr_res_s;
  logic [7:0]       wr_flg_s;

  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       sticky_q, sticky_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;

  logic [LATENCY-1:0] pv_q;
  logic [LATENCY-1:0] pb_q;
  logic [TAG_W-1:0]   ptag_q [LATENCY];

  logic [WIDTH-1:0] mem_res_q [DEPTH];
  logic [7:0]       mem_flg_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];

  logic [2:0]       core_op_q;
  logic [1:0]       core_rmode_q;
  logic [WIDTH-1:0] core_opa_q, core_opb_q;

  // Counting in-flight ops against FIFO space guarantees every issued op a slot.
  always_comb begin
    pending_s = PCW'(inflight_q) + PCW'(count_q);
    if (!rst && (pending_s < PCW'(DEPTH))) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s = bus.in_valid && in_ready_s;
  assign wr_s     = pv_q[LATENCY-1];
  assign pop_s    = (count_q != CW'(0)) && bus.out_ready;

  always_comb begin
    if (pb_q[LATENCY-1]) begin
      wr_res_s = QNAN;
      wr_flg_s = QNAN_FLAGS;
    end else begin
      wr_res_s = bus.core_out;
      wr_flg_s = bus.core_flags;
    end
  end

  always_comb begin
    case ({accept_s, wr_s})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A clear that coincides with a pop keeps only the flags being popped.
  always_comb begin
    if (pop_s) begin
      if (bus.clr_sticky) begin
        sticky_d = mem_flg_q[rd_ptr_q];
      end else begin
        sticky_d = sticky_q | mem_flg_q[rd_ptr_q];
      end
    end else if (bus.clr_sticky) begin
      sticky_d = 8'h00;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q   <= CW'(0);
      count_q      <= CW'(0);
      sticky_q     <= 8'h00;
      wr_ptr_q     <= PW'(0);
      rd_ptr_q     <= PW'(0);
      core_op_q    <= 3'd0;
      core_rmode_q <= 2'd0;
      core_opa_q   <= {WIDTH{1'b0}};
      core_opb_q   <= {WIDTH{1'b0}};
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      if (wr_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (accept_s) begin
        core_op_q    <= bus.in_op;
        core_rmode_q <= bus.in_rmode;
        core_opa_q   <= bus.in_opa;
        core_opb_q   <= bus.in_opb;
      end
    end
  end

  // Tag pipe mirrors the core depth; clearing it on reset drops anything still in the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= {LATENCY{1'b0}};
      pb_q <= {LATENCY{1'b0}};
      for (int k = 0; k < LATENCY; k++) begin
        ptag_q[k] <= {TAG_W{1'b0}};
      end
    end else begin
      pv_q[0]   <= accept_s;
      pb_q[0]   <= accept_s && (bus.in_op == OP_ILLEGAL);
      ptag_q[0] <= accept_s ? bus.in_tag : {TAG_W{1'b0}};
      for (int k = 1; k < LATENCY; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pb_q[k]   <= pb_q[k-1];
        ptag_q[k] <= ptag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_res_q[k] <= {WIDTH{1'b0}};
        mem_flg_q[k] <= 8'h00;
        mem_tag_q[k] <= {TAG_W{1'b0}};
      end
    end else if (wr_s) begin
      mem_res_q[wr_ptr_q] <= wr_res_s;
      mem_flg_q[wr_ptr_q] <= wr_flg_s;
      mem_tag_q[wr_ptr_q] <= ptag_q[LATENCY-1];
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.core_op      = core_op_q;
  assign bus.core_rmode   = core_rmode_q;
  assign bus.core_opa     = core_opa_q;
  assign bus.core_opb     = core_opb_q;
  assign bus.out_valid    = (count_q != CW'(0));
  assign bus.out_result   = mem_res_q[rd_ptr_q];
  assign bus.out_flags    = mem_flg_q[rd_ptr_q];
  assign bus.out_tag      = mem_tag_q[rd_ptr_q];
  assign bus.sticky_flags = sticky_q;
endmodule

// File: tb/tb_fpu_req_shell.sv
// Bench for fpu_req_shell: three configurations, a stand-in core, and a queue model of
// accepted ops checked every cycle, plus directed scenarios with literal expectations.
module tb_fpu_req_shell;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mcyc   = 0;
  bit chk_en = 1'b0;

  logic        drv_rst [N];
  logic        drv_valid [N];
  logic        drv_oready [N];
  logic        drv_clr [N];
  logic [2:0]  drv_op [N];
  logic [1:0]  drv_rm [N];
  logic [63:0] drv_a [N];
  logic [63:0] drv_b [N];
  logic [3:0]  drv_tag [N];

  logic        mon_iready [N];
  logic        mon_ovalid [N];
  logic [63:0] mon_res [N];
  logic [7:0]  mon_flg [N];
  logic [7:0]  mon_sticky [N];
  logic [3:0]  mon_tag [N];
  logic [2:0]  cop [N];
  logic [1:0]  crm [N];
  logic [63:0] ca [N];
  logic [63:0] cb [N];

  logic [71:0] stub_q [N];
  logic [71:0] dl [N][8];

  function automatic int width_of(input int i);
    case (i)
      2:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int depth_of(input int i);
    case (i)
      1:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] qnan_of(input int i);
    if (width_of(i) == 16) return 64'h0000_0000_0000_7E00;
    else return 64'h7FF8_0000_0000_0000;
  endfunction

  // Stand-in core: add returns the larger-magnitude operand with ine; op 7 returns junk.
  function automatic logic [71:0] core_fn(input logic [2:0] op, input logic [1:0] rm,
                                          input logic [63:0] a_in, input logic [63:0] b_in,
                                          input int w);
    logic [63:0] mask, mag, a, b, r;
    logic [7:0]  f;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    mag  = mask >> 1;
    a    = a_in & mask;
    b    = b_in & mask;
    case (op)
      3'd0: begin
        r = ((a & mag) >= (b & mag)) ? a : b;
        f = 8'h10;
      end
      3'd7: begin
        r = 64'hDEAD_BEEF_CAFE_F00D & mask;
        f = 8'hFF;
      end
      default: begin
        r = (a ^ {b[62:0], 1'b0} ^ {61'd0, op} ^ {62'd0, rm}) & mask;
        f = {5'd0, op};
      end
    endcase
    return {r, f};
  endfunction

  task automatic check(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, i, act, exp);
    end
  endtask

  `define HOOK(IDX, BUS, W, L) \
    assign BUS.in_valid   = drv_valid[IDX]; \
    assign BUS.in_op      = drv_op[IDX]; \
    assign BUS.in_rmode   = drv_rm[IDX]; \
    assign BUS.in_opa     = drv_a[IDX][W-1:0]; \
    assign BUS.in_opb     = drv_b[IDX][W-1:0]; \
    assign BUS.in_tag     = drv_tag[IDX]; \
    assign BUS.out_ready  = drv_oready[IDX]; \
    assign BUS.clr_sticky = drv_clr[IDX]; \
    assign BUS.core_out   = dl[IDX][L-2][W+7:8]; \
    assign BUS.core_flags = dl[IDX][L-2][7:0]; \
    assign mon_iready[IDX] = BUS.in_ready; \
    assign mon_ovalid[IDX] = BUS.out_valid; \
    assign mon_res[IDX]    = 64'(BUS.out_result); \
    assign mon_flg[IDX]    = BUS.out_flags; \
    assign mon_sticky[IDX] = BUS.sticky_flags; \
    assign mon_tag[IDX]    = BUS.out_tag; \
    assign cop[IDX]        = BUS.core_op; \
    assign crm[IDX]        = BUS.core_rmode; \
    assign ca[IDX]         = 64'(BUS.core_opa); \
    assign cb[IDX]         = 64'(BUS.core_opb);

  fpu_req_shell_if #(.WIDTH(64), .TAG_W(4)) if0 ();
  fpu_req_shell_if #(.WIDTH(64), .TAG_W(4)) if1 ();
  fpu_req_shell_if #(.WIDTH(16), .TAG_W(4)) if2 ();

  `HOOK(0, if0, 64, 4)
  `HOOK(1, if1, 64, 4)
  `HOOK(2, if2, 16, 3)

  fpu_req_shell #(.WIDTH(64), .LATENCY(4), .DEPTH(4), .TAG_W(4)) u_dut0 (.clk(clk), .rst(drv_rst[0]), .bus(if0));
  fpu_req_shell #(.WIDTH(64), .LATENCY(4), .DEPTH(8), .TAG_W(4)) u_dut1 (.clk(clk), .rst(drv_rst[1]), .bus(if1));
  fpu_req_shell #(.WIDTH(16), .LATENCY(3), .DEPTH(4), .TAG_W(4)) u_dut2 (.clk(clk), .rst(drv_rst[2]), .bus(if2));

  // Core stand-in: result computed from registered core inputs, delayed to emerge LATENCY cycles later.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) stub_q[i] <= core_fn(cop[i], crm[i], ca[i], cb[i], width_of(i));
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      dl[i][0] <= stub_q[i];
      for (int k = 1; k < 8; k++) dl[i][k] <= dl[i][k-1];
    end
  end

  // Model: every accepted op waits in order, becomes visible LATENCY cycles after acceptance.
  logic [63:0] m_res [N][32];
  logic [7:0]  m_flg [N][32];
  logic [3:0]  m_tag [N][32];
  int          m_rdy [N][32];
  int          m_head [N];
  int          m_cnt [N];
  logic [7:0]  m_sticky [N];
  logic        m_ready, m_ov;
  logic [71:0] m_cf;
  int          m_idx, m_h;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_head[i] = 0; m_cnt[i] = 0; m_sticky[i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        m_h     = m_head[i];
        m_ready = !drv_rst[i] && (m_cnt[i] < depth_of(i));
        m_ov    = (m_cnt[i] > 0) && (m_rdy[i][m_h] <= mcyc);
        if (chk_en) begin
          check("in_ready", i, 64'(mon_iready[i]), 64'(m_ready));
          check("out_valid", i, 64'(mon_ovalid[i]), 64'(m_ov));
          check("sticky", i, 64'(mon_sticky[i]), 64'(m_sticky[i]));
          if (m_ov) begin
            check("out_result", i, mon_res[i], m_res[i][m_h]);
            check("out_flags", i, 64'(mon_flg[i]), 64'(m_flg[i][m_h]));
            check("out_tag", i, 64'(mon_tag[i]), 64'(m_tag[i][m_h]));
          end
        end
        if (drv_rst[i]) begin
          m_head[i] = 0; m_cnt[i] = 0; m_sticky[i] = 8'h00;
        end else begin
          if (m_ov && drv_oready[i]) begin
            m_sticky[i] = drv_clr[i] ? m_flg[i][m_h] : (m_sticky[i] | m_flg[i][m_h]);
            m_head[i]   = (m_head[i] + 1) % 32;
            m_cnt[i]    = m_cnt[i] - 1;
          end else if (drv_clr[i]) begin
            m_sticky[i] = 8'h00;
          end
          if (drv_valid[i] && m_ready) begin
            m_idx = (m_head[i] + m_cnt[i]) % 32;
            m_cf  = core_fn(drv_op[i], drv_rm[i], drv_a[i], drv_b[i], width_of(i));
            m_res[i][m_idx] = (drv_op[i] == 3'd7) ? qnan_of(i) : m_cf[71:8];
            m_flg[i][m_idx] = (drv_op[i] == 3'd7) ? 8'h40 : m_cf[7:0];
            m_tag[i][m_idx] = drv_tag[i];
            m_rdy[i][m_idx] = mcyc + 1 + lat_of(i);
            m_cnt[i]        = m_cnt[i] + 1;
          end
        end
      end
      mcyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input int i, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] tag);
    drv_valid[i] = 1'b1; drv_op[i] = op; drv_rm[i] = 2'd0;
    drv_a[i] = a; drv_b[i] = b; drv_tag[i] = tag;
  endtask

  logic        will;
  logic [11:0] seq;
  logic [3:0]  tg;
  int          acc, seen, first, ones, rises;
  logic        prev_ov;

  initial begin
    for (int i = 0; i < N; i++) begin
      drv_rst[i] = 1'b1; drv_valid[i] = 1'b0; drv_oready[i] = 1'b0; drv_clr[i] = 1'b0;
      drv_op[i] = 3'd0; drv_rm[i] = 2'd0; drv_a[i] = 64'd0; drv_b[i] = 64'd0; drv_tag[i] = 4'd0;
    end
    repeat (3) tick();
    for (int i = 0; i < N; i++) check("ready_in_rst", i, 64'(mon_iready[i]), 64'd0);
    chk_en = 1'b1;
    for (int i = 0; i < N; i++) drv_rst[i] = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      check("ready_after_rst", i, 64'(mon_iready[i]), 64'd1);
      check("result_after_rst", i, mon_res[i], 64'd0);
      check("sticky_after_rst", i, 64'(mon_sticky[i]), 64'd0);
    end

    // Single add: accept-to-out_valid is LATENCY cycles.
    drv_oready[0] = 1'b1;
    drive_op(0, 3'd0, 64'h1915_36e3_e743_a545, 64'hf5ce_b434_501d_c11c, 4'd3);
    tick();
    drv_valid[0] = 1'b0;
    repeat (3) tick();
    check("lat_not_yet", 0, 64'(mon_ovalid[0]), 64'd0);
    tick();
    check("lat_valid", 0, 64'(mon_ovalid[0]), 64'd1);
    check("add_result", 0, mon_res[0], 64'hf5ce_b434_501d_c11c);
    check("add_flags", 0, 64'(mon_flg[0]), 64'h10);
    check("add_tag", 0, 64'(mon_tag[0]), 64'd3);
    tick();
    check("sticky_ine", 0, 64'(mon_sticky[0]), 64'h10);

    // Illegal op between two adds keeps program order and returns canonical QNaN.
    drive_op(0, 3'd0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd1); tick();
    drive_op(0, 3'd7, 64'h1234_0000_0000_0000, 64'h5678_0000_0000_0000, 4'd2); tick();
    drive_op(0, 3'd0, 64'hC010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 4'd3); tick();
    drv_valid[0] = 1'b0;
    seq = 12'h000; seen = 0;
    for (int n = 0; n < 20 && seen < 3; n++) begin
      tick();
      if (mon_ovalid[0]) begin
        seq = {seq[7:0], mon_tag[0]};
        seen++;
        if (mon_tag[0] == 4'd2) begin
          check("qnan_result", 0, mon_res[0], 64'h7FF8_0000_0000_0000);
          check("qnan_flags", 0, 64'(mon_flg[0]), 64'h40);
        end
      end
    end
    check("order_123", 0, 64'(seq), 64'h123);
    tick();
    check("sticky_qnan", 0, 64'(mon_sticky[0] & 8'h40), 64'h40);

    // Full FIFO: 4 accepted with out_ready low, then the pop reopens in_ready.
    drv_oready[0] = 1'b0; acc = 0; tg = 4'd4;
    drive_op(0, 3'd2, 64'h4000_0000_0000_0004, 64'h4008_0000_0000_0000, tg);
    for (int n = 0; n < 8; n++) begin
      will = mon_iready[0] && drv_valid[0];
      tick();
      if (will) begin
        acc++; tg = tg + 4'd1;
        drive_op(0, 3'd2, 64'h4000_0000_0000_0000 + 64'(tg), 64'h4008_0000_0000_0000, tg);
        if (acc == 4) check("full_at_4th", 0, 64'(mon_iready[0]), 64'd0);
      end
    end
    check("accepted_4", 0, 64'(acc), 64'd4);
    drv_oready[0] = 1'b1; first = -1;
    for (int n = 0; n < 10 && acc < 6; n++) begin
      will = mon_iready[0] && drv_valid[0];
      tick();
      if (will) begin
        acc++; tg = tg + 4'd1;
        if (first < 0) first = n;
        if (acc == 6) drv_valid[0] = 1'b0;
        else drive_op(0, 3'd2, 64'h4000_0000_0000_0000 + 64'(tg), 64'h4008_0000_0000_0000, tg);
      end
    end
    drv_valid[0] = 1'b0;
    check("pop_to_ready", 0, 64'(first), 64'd1);
    check("accepted_6", 0, 64'(acc), 64'd6);
    repeat (12) tick();

    // Back-to-back stream through DEPTH=8: one result per cycle, pointers wrap twice.
    drv_oready[1] = 1'b1; acc = 0; ones = 0; rises = 0; prev_ov = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (n < 16) drive_op(1, 3'(n % 7), {32'(n), 32'h1234_5678}, 64'h0F0F_0000_0000_0000 ^ 64'(n), 4'(n));
      else drv_valid[1] = 1'b0;
      will = mon_iready[1] && drv_valid[1];
      tick();
      if (will) acc++;
      if (mon_ovalid[1]) ones++;
      if (mon_ovalid[1] && !prev_ov) rises++;
      prev_ov = mon_ovalid[1];
    end
    check("stream_accepts", 1, 64'(acc), 64'd16);
    check("stream_results", 1, 64'(ones), 64'd16);
    check("stream_continuous", 1, 64'(rises), 64'd1);

    // Reset with 2 buffered and 3 in flight discards everything.
    check("sticky_before_rst", 1, 64'(mon_sticky[1] != 8'h00), 64'd1);
    drv_oready[1] = 1'b0;
    drive_op(1, 3'd3, 64'd11, 64'd12, 4'd1); tick();
    drive_op(1, 3'd3, 64'd13, 64'd14, 4'd2); tick();
    drv_valid[1] = 1'b0;
    repeat (5) tick();
    drive_op(1, 3'd1, 64'd21, 64'd22, 4'd3); tick();
    drive_op(1, 3'd1, 64'd23, 64'd24, 4'd4); tick();
    drive_op(1, 3'd1, 64'd25, 64'd26, 4'd5); tick();
    drv_valid[1] = 1'b0; drv_rst[1] = 1'b1;
    tick();
    check("rst_out_valid", 1, 64'(mon_ovalid[1]), 64'd0);
    check("rst_sticky", 1, 64'(mon_sticky[1]), 64'd0);
    drv_rst[1] = 1'b0; drv_oready[1] = 1'b1;
    tick();
    check("rst_release_ready", 1, 64'(mon_iready[1]), 64'd1);
    for (int n = 0; n < 8; n++) begin
      check("no_stale", 1, 64'(mon_ovalid[1]), 64'd0);
      tick();
    end

    // WIDTH=16: illegal op popped together with clr_sticky leaves exactly its flags.
    drv_oready[2] = 1'b1;
    drive_op(2, 3'd0, 64'h3C00, 64'h4000, 4'd1); tick();
    drv_valid[2] = 1'b0;
    repeat (6) tick();
    check("w16_sticky_add", 2, 64'(mon_sticky[2]), 64'h10);
    drv_oready[2] = 1'b0;
    drive_op(2, 3'd7, 64'h1111, 64'h2222, 4'd5); tick();
    drv_valid[2] = 1'b0;
    for (int n = 0; n < 10 && !mon_ovalid[2]; n++) tick();
    check("w16_valid", 2, 64'(mon_ovalid[2]), 64'd1);
    check("w16_qnan", 2, mon_res[2], 64'h7E00);
    check("w16_flags", 2, 64'(mon_flg[2]), 64'h40);
    check("w16_tag", 2, 64'(mon_tag[2]), 64'd5);
    drv_clr[2] = 1'b1; drv_oready[2] = 1'b1;
    tick();
    drv_clr[2] = 1'b0;
    check("w16_sticky_clr_pop", 2, 64'(mon_sticky[2]), 64'h40);
    check("w16_drained", 2, 64'(mon_ovalid[2]), 64'd0);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
